nrs_seq_buffer: RTL and testbench

//  Multi-bank successor to the single-symbol NRS bit register: buffers serial Gold-sequence bits c(n)
//  for NUM_BANKS OFDM symbols, so the generator fills bank k+1 while channel estimation reads bank k.

---
 rtl/nrs_pkg.sv | 9 +
 rtl/nrs_bank_ctrl.sv | 93 +++++++++
 rtl/nrs_seq_buffer.sv | 97 +++++++++
 tb/tb_nrs_seq_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// Shared constants for the NRS Gold-sequence symbol buffer.
package nrs_pkg;
    localparam int NRS_WIDTH_REG = 16;
    localparam int NRS_NUM_BANKS = 2;
    localparam int NRS_NUM_RD    = 2;
    // Read port roles
    localparam int RD_EST        = 0;
    localparam int RD_FINE       = 1;
endpackage

// File: rtl/nrs_bank_ctrl.sv
// Bank bookkeeping for the NRS sequence buffer.
// Tracks the fill bank and bit position, the bank being read, how many banks are full,
// and the sticky overflow/underflow flags. Each bank moves FREE -> FILLING -> FULL -> READING -> FREE,
// implied entirely by wr_ptr, rd_ptr and count.
module nrs_bank_ctrl
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG = NRS_WIDTH_REG,
    parameter int NUM_BANKS = NRS_NUM_BANKS,
    parameter int LINES     = $clog2(WIDTH_REG),
    parameter int BLINES    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic              rd_release,
    output logic              wr_en,
    output logic [BLINES-1:0] wr_ptr,
    output logic [BLINES-1:0] rd_ptr,
    output logic [LINES-1:0]  bit_cnt,
    output logic              wr_ready,
    output logic              rd_avail,
    output logic              overflow,
    output logic              underflow
);
    localparam int CNT_W = BLINES + 1;

    logic [BLINES-1:0] wr_ptr_q, wr_ptr_d;
    logic [BLINES-1:0] rd_ptr_q, rd_ptr_d;
    logic [LINES-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rel_en;
    logic              bank_done;

    // Handshake decode and next-state for pointers, fill position, bank count and flags
    always_comb begin
        wr_ready    = (count_q < CNT_W'(NUM_BANKS));
        rd_avail    = (count_q != '0);
        wr_en       = wr_valid & wr_ready;
        rel_en      = rd_release & rd_avail;
        bank_done   = wr_en && (bit_cnt_q == LINES'(WIDTH_REG - 1));

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bit_cnt_d   = bit_cnt_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_valid & ~wr_ready);
        underflow_d = underflow_q | (rd_release & ~rd_avail);

        if (wr_en) begin
            bit_cnt_d = bank_done ? '0 : bit_cnt_q + LINES'(1);
        end
        if (bank_done) begin
            wr_ptr_d = wr_ptr_q + BLINES'(1);
        end
        if (rel_en) begin
            rd_ptr_d = rd_ptr_q + BLINES'(1);
        end
        // A bank completing while another is released leaves the count unchanged
        case ({bank_done, rel_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bit_cnt_q   <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bit_cnt_q   <= bit_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign bit_cnt   = bit_cnt_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: rtl/nrs_seq_buffer.sv
// Multi-bank buffer for serial NRS Gold-sequence bits c(n).
// The generator fills one bank while the estimator reads a completed one; each read
// port returns a QPSK pair (even bit = real, odd bit = imag, optionally conjugated).
module nrs_seq_buffer
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG = NRS_WIDTH_REG,
    parameter int NUM_BANKS = NRS_NUM_BANKS,
    parameter int NUM_RD    = NRS_NUM_RD,
    parameter int LINES     = $clog2(WIDTH_REG),
    parameter int BLINES    = $clog2(NUM_BANKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    c_n,
    output logic                    rd_avail,
    output logic [BLINES-1:0]       rd_bank,
    input  logic                    rd_release,
    input  logic [NUM_RD-1:0]       rd_conj,
    input  logic [NUM_RD*LINES-1:0] rd_addr,
    output logic [NUM_RD-1:0]       c_n_r,
    output logic [NUM_RD-1:0]       c_n_i,
    output logic                    overflow,
    output logic                    underflow
);
    logic              wr_en;
    logic [BLINES-1:0] wr_ptr;
    logic [BLINES-1:0] rd_ptr;
    logic [LINES-1:0]  bit_cnt;

    logic [WIDTH_REG-1:0] bank_q [NUM_BANKS];
    logic [WIDTH_REG-1:0] bank_d [NUM_BANKS];

    nrs_bank_ctrl #(
        .WIDTH_REG (WIDTH_REG),
        .NUM_BANKS (NUM_BANKS),
        .LINES     (LINES),
        .BLINES    (BLINES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .rd_release (rd_release),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .bit_cnt    (bit_cnt),
        .wr_ready   (wr_ready),
        .rd_avail   (rd_avail),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    assign rd_bank = rd_ptr;

    // Bank storage: flops rather than RAM, since reset must clear every bit
    // and the read ports are combinational.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        // Insert the incoming bit at the fill position of the active bank
        always_comb begin
            bank_d[gi] = bank_q[gi];
            if (wr_en && (wr_ptr == BLINES'(gi))) begin
                bank_d[gi][bit_cnt] = c_n;
            end
        end

        // Bank register with synchronous clear
        always_ff @(posedge clk) begin
            if (rst) begin
                bank_q[gi] <= '0;
            end else begin
                bank_q[gi] <= bank_d[gi];
            end
        end
    end

    // One QPSK read mux per port; the address LSB is ignored so a pair is always even-aligned
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [LINES-1:0] addr;
        logic [LINES-1:0] re_idx;
        logic [LINES-1:0] im_idx;
        logic             unused_addr_lsb;

        assign addr            = rd_addr[gi*LINES +: LINES];
        assign unused_addr_lsb = addr[0];

        // Real/imag bit select from the current read bank
        always_comb begin
            re_idx    = {addr[LINES-1:1], 1'b0};
            im_idx    = {addr[LINES-1:1], 1'b1};
            c_n_r[gi] = bank_q[rd_ptr][re_idx];
            c_n_i[gi] = bank_q[rd_ptr][im_idx] ^ rd_conj[gi];
        end
    end
endmodule

// File: tb/tb_nrs_seq_buffer.sv
// Self-checking bench for nrs_seq_buffer: directed scenarios followed by random traffic,
// compared against a queue-of-symbols reference model.
module tb_nrs_seq_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic       c_n;
    logic       rd_avail;
    logic [0:0] rd_bank;
    logic       rd_release;
    logic [1:0] rd_conj;
    logic [7:0] rd_addr;
    logic [1:0] c_n_r;
    logic [1:0] c_n_i;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: completed symbols waiting to be read, plus the symbol being filled
    logic [15:0] m_q[$];
    logic [15:0] m_part;
    int          m_nbits;
    int          m_rd_idx;
    logic        m_ovf;
    logic        m_unf;

    nrs_seq_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .c_n        (c_n),
        .rd_avail   (rd_avail),
        .rd_bank    (rd_bank),
        .rd_release (rd_release),
        .rd_conj    (rd_conj),
        .rd_addr    (rd_addr),
        .c_n_r      (c_n_r),
        .c_n_i      (c_n_i),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_part   = '0;
        m_nbits  = 0;
        m_rd_idx = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // Compare every visible output against the model for the inputs currently driven
    task automatic model_check();
        logic [15:0] w;
        logic [3:0]  a;
        logic [3:0]  re_b;
        logic [3:0]  im_b;
        check("wr_ready",  {31'd0, wr_ready},  {31'd0, m_q.size() < 2});
        check("rd_avail",  {31'd0, rd_avail},  {31'd0, m_q.size() != 0});
        check("rd_bank",   {31'd0, rd_bank},   m_rd_idx);
        check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        check("underflow", {31'd0, underflow}, {31'd0, m_unf});
        if (m_q.size() != 0) begin
            w = m_q[0];
            for (int p = 0; p < 2; p++) begin
                a    = rd_addr[p*4 +: 4];
                re_b = a & 4'he;
                im_b = re_b + 4'd1;
                check("data_re", {31'd0, c_n_r[p]}, {31'd0, w[re_b]});
                check("data_im", {31'd0, c_n_i[p]}, {31'd0, w[im_b] ^ rd_conj[p]});
            end
        end
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input logic wv, input logic cn, input logic rel);
        bit ready;
        bit avail;
        ready = (m_q.size() < 2);
        avail = (m_q.size() != 0);
        if (wv && !ready) m_ovf = 1'b1;
        if (rel && !avail) m_unf = 1'b1;
        if (rel && avail) begin
            void'(m_q.pop_front());
            m_rd_idx = (m_rd_idx + 1) % 2;
        end
        if (wv && ready) begin
            m_part[m_nbits] = cn;
            m_nbits++;
            if (m_nbits == 16) begin
                m_q.push_back(m_part);
                m_part  = '0;
                m_nbits = 0;
            end
        end
    endtask

    task automatic do_cycle(input logic wv, input logic cn, input logic rel,
                            input logic [1:0] conj, input logic [7:0] addr);
        @(negedge clk);
        wr_valid   = wv;
        c_n        = cn;
        rd_release = rel;
        rd_conj    = conj;
        rd_addr    = addr;
        #1;
        model_check();
        model_step(wv, cn, rel);
        @(posedge clk);
    endtask

    // Hold inputs idle (no state change) and present a read address for direct checks
    task automatic peek(input logic [1:0] conj, input logic [7:0] addr);
        @(negedge clk);
        wr_valid   = 1'b0;
        rd_release = 1'b0;
        rd_conj    = conj;
        rd_addr    = addr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        wr_valid   = 1'b0;
        rd_release = 1'b0;
        rd_conj    = 2'b01;
        rd_addr    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
    endtask

    task automatic fill(input logic [15:0] word, input int nbits, input bit rel_last);
        for (int i = 0; i < nbits; i++) begin
            do_cycle(1'b1, word[i], rel_last && (i == nbits - 1), 2'b00, 8'h00);
        end
    endtask

    initial begin
        rst        = 1'b1;
        wr_valid   = 1'b0;
        c_n        = 1'b0;
        rd_release = 1'b0;
        rd_conj    = 2'b00;
        rd_addr    = 8'h00;
        model_clear();

        // Reset state
        do_reset();
        check("rst_wr_ready",  {31'd0, wr_ready},  32'd1);
        check("rst_rd_avail",  {31'd0, rd_avail},  32'd0);
        check("rst_rd_bank",   {31'd0, rd_bank},   32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);
        check("rst_c_n_r",     {30'd0, c_n_r},     32'd0);
        check("rst_c_n_i",     {30'd0, c_n_i},     32'd1);

        // Bank 0 <= A5C3, readable the cycle after its last bit
        fill(16'hA5C3, 16, 1'b0);
        peek(2'b00, 8'h20);
        check("fill0_avail", {31'd0, rd_avail}, 32'd1);
        check("fill0_r",     {30'd0, c_n_r},    32'd1);
        check("fill0_i",     {30'd0, c_n_i},    32'd1);

        // Conjugate on port 1 with an odd address
        peek(2'b10, 8'h30);
        check("conj_r1", {31'd0, c_n_r[1]}, 32'd0);
        check("conj_i1", {31'd0, c_n_i[1]}, 32'd1);

        // Bank 1 completes in the same cycle bank 0 is released
        fill(16'h3C96, 16, 1'b1);
        peek(2'b00, 8'h00);
        check("sim_avail",    {31'd0, rd_avail}, 32'd1);
        check("sim_rd_bank",  {31'd0, rd_bank},  32'd1);
        check("sim_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("sim_r0",       {31'd0, c_n_r[0]}, 32'd0);
        check("sim_i0",       {31'd0, c_n_i[0]}, 32'd1);

        // Fill the free bank: buffer full, the extra bit is dropped
        fill(16'h0F0F, 16, 1'b0);
        peek(2'b00, 8'h00);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        do_cycle(1'b1, 1'b1, 1'b0, 2'b00, 8'h00);
        peek(2'b00, 8'h00);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        check("full_keep_r0",  {31'd0, c_n_r[0]}, 32'd0);
        check("full_keep_i0",  {31'd0, c_n_i[0]}, 32'd1);

        // Drain both banks, then release with nothing readable
        do_cycle(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
        peek(2'b00, 8'h00);
        check("unf_flag",  {31'd0, underflow}, 32'd1);
        check("unf_avail", {31'd0, rd_avail},  32'd0);

        // Reset in the middle of a fill discards the partial bank
        fill(16'hFFFF, 7, 1'b0);
        do_reset();
        check("mid_avail",    {31'd0, rd_avail},  32'd0);
        check("mid_overflow", {31'd0, overflow},  32'd0);
        check("mid_underflow",{31'd0, underflow}, 32'd0);
        check("mid_wr_ready", {31'd0, wr_ready},  32'd1);
        fill(16'h1234, 16, 1'b0);
        peek(2'b00, 8'h20);
        check("mid_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("mid_r",       {30'd0, c_n_r},   32'd2);
        check("mid_i",       {30'd0, c_n_i},   32'd0);

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                do_cycle($urandom_range(0, 3) != 0, 1'($urandom),
                         $urandom_range(0, 15) == 0, 2'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
